ccc_reconfig_ctrl: RTL and testbench
====================================

Name: ccc_reconfig_ctrl

Overview:
- APB master sequencer that reprograms a dynamic CCC/PLL (CCCDYN-style 8-bit APB slave, PADDR[7:2]) at runtime.
- Holds a shadow image of NUM_REGS config bytes, loaded by fabric logic.
- On start, it holds the PLL in reset, burst-writes the image over APB, releases reset and waits for lock with a timeout.
- Sits between the system controller / soft CPU and the CCC APB port.

Parameters:
- NUM_REGS, 8, number of config bytes written per reconfiguration (1..64).
- BASE_ADDR, 6'h00, word address (PADDR[7:2]) of the first config register; byte i goes to BASE_ADDR+i (6-bit wrap).
- RST_CYCLES, 16, cycles PLL_ARST_N is held low before the first APB write.
- APB_TIMEOUT, 64, max wait cycles for PREADY per access.
- LOCK_TIMEOUT, 65535, max cycles to wait for synchronized LOCK after reset release.

Ports:
- APB_S_PCLK  in  1  clock, also the CCC APB clock.
- APB_S_PRESET  in  1  asynchronous active-high reset.
- CFG_WE  in  1  shadow image write strobe.
- CFG_ADDR  in  6  shadow index (values >= NUM_REGS ignored).
- CFG_WDATA  in  8  shadow byte.
- START  in  1  single-cycle reconfiguration request.
- CCC_BUSY  in  1  CCC BUSY output; the block does not start while it is high.
- LOCK  in  1  CCC LOCK output, asynchronous to APB_S_PCLK.
- APB_M_PSEL  out  1  APB select to CCC.
- APB_M_PENABLE  out  1  APB enable.
- APB_M_PWRITE  out  1  always 1 during access.
- APB_M_PADDR  out  6  word address.
- APB_M_PWDATA  out  8  write data.
- APB_M_PREADY  in  1  slave ready.
- APB_M_PSLVERR  in  1  slave error.
- PLL_ARST_N  out  1  PLL reset to CCC, active low.
- ACTIVE  out  1  high while not in IDLE.
- DONE  out  1  one-cycle pulse when sequence completes (success or error).
- ERR  out  2  status of last sequence: 00 ok, 01 PSLVERR, 10 PREADY timeout, 11 lock timeout; held until next START.
- LOCKED  out  1  synchronized LOCK (2-flop).

Behaviour:
- Reset values: APB_M_* outputs 0; PLL_ARST_N=1; ACTIVE=0; DONE=0; ERR=00; LOCKED=0; shadow image all 0; state IDLE.
- Shadow image: written on CFG_WE when state==IDLE; CFG_WE outside IDLE is ignored.
- LOCK passes through a 2-flop synchronizer; all decisions use LOCKED.
- IDLE:
  - START=1 and CCC_BUSY=0 -> PRST; ERR cleared, idx=0, PLL_ARST_N=0.
  - START while CCC_BUSY=1 is dropped (not queued).
  - START outside IDLE is ignored.
- PRST: count RST_CYCLES cycles with PLL_ARST_N=0, then -> SETUP.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PWRITE=1, PADDR=BASE_ADDR+idx, PWDATA=shadow[idx] -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address/data stable. Waits for PREADY, counting wait cycles.
  - PREADY & PSLVERR -> ERR=01 -> FIN.
  - PREADY & !PSLVERR: if idx==NUM_REGS-1 -> RELEASE, else idx++ -> SETUP (no idle cycle between transfers).
  - Wait counter reaches APB_TIMEOUT without PREADY -> ERR=10 -> FIN.
- RELEASE (1 cycle): PLL_ARST_N=1, lock counter cleared -> WAIT_LOCK.
- WAIT_LOCK:
  - LOCKED=1 -> FIN with ERR=00.
  - Counter reaches LOCK_TIMEOUT -> ERR=11 -> FIN.
- FIN (1 cycle): DONE=1, PSEL/PENABLE=0, PLL_ARST_N=1 -> IDLE.
- Error paths always leave PLL_ARST_N=1 (PLL is released even on error).
- APB outputs drop to 0 in the cycle after the last accepted access.
- Minimum latency, START to DONE, with zero-wait PREADY and immediate lock:
  - 1 + RST_CYCLES + 2*NUM_REGS + 1 + (lock cycles + 2 for the synchronizer) + 1.
- Async reset mid-sequence: everything returns to reset values immediately and PLL_ARST_N goes to 1; the shadow image is lost.
- Counters are sized with $clog2 of (timeout+1); no wrap is possible before the compare.

Decomposition:
- Package ccc_reconfig_pkg holds:
  - the state enum (IDLE, PRST, SETUP, ACCESS, RELEASE, WAIT_LOCK, FIN);
  - the ERR code constants (ERR_OK, ERR_SLVERR, ERR_TIMEOUT, ERR_NOLOCK).
- One sub-module, ccc_sync2: generic 2-flop synchronizer with async active-high reset, used for LOCK.

Test Plan:
- Load bytes 8'h10..8'h17, START, PREADY tied 1, LOCK rising 20 cycles after release:
  - 8 writes to PADDR 0..7 with data 10..17, each 2 cycles;
  - PLL_ARST_N low for 16 cycles before the first PSEL;
  - DONE pulse and ERR=00.
- PREADY delayed 3 cycles on write 4: PENABLE held 4 cycles with stable PADDR=4 / PWDATA=8'h14, then the sequence continues normally.
- PSLVERR with PREADY on write 2: no write 3 issued, ERR=01, DONE pulse, PLL_ARST_N=1.
- PREADY held 0: exactly APB_TIMEOUT wait cycles in ACCESS, then ERR=10 and DONE.
- LOCK held 0 with LOCK_TIMEOUT=100: DONE after 100 cycles in WAIT_LOCK with ERR=11.
- START while CCC_BUSY=1: no APB activity. Then CFG_WE during an active sequence (busy), then async reset mid-write:
  - the CFG_WE write is ignored (shadow unchanged on the next run);
  - the reset clears all outputs and forces PLL_ARST_N=1.

Source files
------------

// File: rtl/ccc_reconfig_pkg.sv
// Shared types for the CCC/PLL dynamic reconfiguration sequencer.
package ccc_reconfig_pkg;

    typedef enum logic [2:0] {
        IDLE, PRST, SETUP, ACCESS, RELEASE, WAIT_LOCK, FIN
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SLVERR  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_NOLOCK  = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ccc_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset.
module ccc_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/ccc_reconfig_ctrl.sv
// APB write sequencer: holds the PLL in reset, burst-writes a shadow config
// image into a CCCDYN-style slave, releases reset and waits for lock.
module ccc_reconfig_ctrl
    import ccc_reconfig_pkg::*;
#(
    parameter int         NUM_REGS     = 8,
    parameter logic [5:0] BASE_ADDR    = 6'h00,
    parameter int         RST_CYCLES   = 16,
    parameter int         APB_TIMEOUT  = 64,
    parameter int         LOCK_TIMEOUT = 65535
) (
    input  logic       APB_S_PCLK,
    input  logic       APB_S_PRESET,
    input  logic       CFG_WE,
    input  logic [5:0] CFG_ADDR,
    input  logic [7:0] CFG_WDATA,
    input  logic       START,
    input  logic       CCC_BUSY,
    input  logic       LOCK,
    output logic       APB_M_PSEL,
    output logic       APB_M_PENABLE,
    output logic       APB_M_PWRITE,
    output logic [5:0] APB_M_PADDR,
    output logic [7:0] APB_M_PWDATA,
    input  logic       APB_M_PREADY,
    input  logic       APB_M_PSLVERR,
    output logic       PLL_ARST_N,
    output logic       ACTIVE,
    output logic       DONE,
    output logic [1:0] ERR,
    output logic       LOCKED
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = max3($clog2(RST_CYCLES + 1), $clog2(APB_TIMEOUT + 1),
                                $clog2(LOCK_TIMEOUT + 1));

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               psel_q, penable_q, pwrite_q;
    logic [5:0]         paddr_q;
    logic [7:0]         pwdata_q;
    logic               arst_n_q, active_q, done_q;
    logic [1:0]         err_q;
    logic [7:0]         shadow_q [DEPTH];
    logic               locked;
    logic               fin_d;
    logic [1:0]         fin_err_d;

    ccc_sync2 u_lock_sync (
        .clk_i (APB_S_PCLK),
        .rst_i (APB_S_PRESET),
        .d_i   (LOCK),
        .q_o   (locked)
    );

    // The image may only change while no sequence is reading it.
    always_ff @(posedge APB_S_PCLK or posedge APB_S_PRESET) begin
        if (APB_S_PRESET) begin
            for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
        end else if (CFG_WE && state_q == IDLE && ({1'b0, CFG_ADDR} < 7'(NUM_REGS))) begin
            shadow_q[CFG_ADDR[IDX_W-1:0]] <= CFG_WDATA;
        end
    end

    assign idx_d = idx_q + 1'b1;

    // Every termination path (error or lock) funnels through FIN.
    always_comb begin
        fin_d     = 1'b0;
        fin_err_d = ERR_OK;
        case (state_q)
            ACCESS: begin
                if (APB_M_PREADY && APB_M_PSLVERR) begin
                    fin_d     = 1'b1;
                    fin_err_d = ERR_SLVERR;
                end else if (!APB_M_PREADY && cnt_q == CNT_W'(APB_TIMEOUT - 1)) begin
                    fin_d     = 1'b1;
                    fin_err_d = ERR_TIMEOUT;
                end
            end
            WAIT_LOCK: begin
                if (locked) begin
                    fin_d = 1'b1;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    fin_d     = 1'b1;
                    fin_err_d = ERR_NOLOCK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge APB_S_PCLK or posedge APB_S_PRESET) begin
        if (APB_S_PRESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            arst_n_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
        end else begin
            done_q <= 1'b0;
            if (fin_d) begin
                state_q   <= FIN;
                err_q     <= fin_err_d;
                done_q    <= 1'b1;
                psel_q    <= 1'b0;
                penable_q <= 1'b0;
                pwrite_q  <= 1'b0;
                paddr_q   <= '0;
                pwdata_q  <= '0;
                arst_n_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (START && !CCC_BUSY) begin
                            state_q  <= PRST;
                            err_q    <= ERR_OK;
                            idx_q    <= '0;
                            cnt_q    <= '0;
                            arst_n_q <= 1'b0;
                            active_q <= 1'b1;
                        end
                    end
                    PRST: begin
                        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                            state_q  <= SETUP;
                            cnt_q    <= '0;
                            psel_q   <= 1'b1;
                            pwrite_q <= 1'b1;
                            paddr_q  <= BASE_ADDR + 6'(idx_q);
                            pwdata_q <= shadow_q[idx_q];
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    SETUP: begin
                        state_q   <= ACCESS;
                        penable_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                    ACCESS: begin
                        // cnt_q counts PREADY-low cycles of the current access
                        if (APB_M_PREADY) begin
                            cnt_q <= '0;
                            if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                                state_q   <= RELEASE;
                                psel_q    <= 1'b0;
                                penable_q <= 1'b0;
                                pwrite_q  <= 1'b0;
                                paddr_q   <= '0;
                                pwdata_q  <= '0;
                                arst_n_q  <= 1'b1;
                            end else begin
                                state_q   <= SETUP;
                                idx_q     <= idx_d;
                                penable_q <= 1'b0;
                                paddr_q   <= BASE_ADDR + 6'(idx_d);
                                pwdata_q  <= shadow_q[idx_d];
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RELEASE: begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end
                    WAIT_LOCK: cnt_q <= cnt_q + 1'b1;
                    FIN: begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign APB_M_PSEL    = psel_q;
    assign APB_M_PENABLE = penable_q;
    assign APB_M_PWRITE  = pwrite_q;
    assign APB_M_PADDR   = paddr_q;
    assign APB_M_PWDATA  = pwdata_q;
    assign PLL_ARST_N    = arst_n_q;
    assign ACTIVE        = active_q;
    assign DONE          = done_q;
    assign ERR           = err_q;
    assign LOCKED        = locked;
endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// Randomized self-checking bench for ccc_reconfig_ctrl with an APB slave model.
module tb_ccc_reconfig_ctrl;
    localparam int         NR = 8;
    localparam logic [5:0] BA = 6'h00;
    localparam int         RC = 16;
    localparam int         AT = 64;
    localparam int         LT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       CFG_WE = 0, START = 0, CCC_BUSY = 0, LOCK = 0;
    logic [5:0] CFG_ADDR = '0;
    logic [7:0] CFG_WDATA = '0;
    logic       PREADY = 0, PSLVERR = 0;
    logic       PSEL, PENABLE, PWRITE, ARST_N, ACTIVE, DONE, LOCKED;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [1:0] ERR;

    ccc_reconfig_ctrl #(.NUM_REGS(NR), .BASE_ADDR(BA), .RST_CYCLES(RC),
                        .APB_TIMEOUT(AT), .LOCK_TIMEOUT(LT)) dut (
        .APB_S_PCLK(clk), .APB_S_PRESET(rst), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
        .CFG_WDATA(CFG_WDATA), .START(START), .CCC_BUSY(CCC_BUSY), .LOCK(LOCK),
        .APB_M_PSEL(PSEL), .APB_M_PENABLE(PENABLE), .APB_M_PWRITE(PWRITE),
        .APB_M_PADDR(PADDR), .APB_M_PWDATA(PWDATA), .APB_M_PREADY(PREADY),
        .APB_M_PSLVERR(PSLVERR), .PLL_ARST_N(ARST_N), .ACTIVE(ACTIVE), .DONE(DONE),
        .ERR(ERR), .LOCKED(LOCKED));

    always #5 clk = ~clk;

    int pass_cnt = 0, chk_cnt = 0;
    logic [7:0] shadow_m [NR];
    int waits [64];
    int slverr_idx = -1;
    bit stuck = 0;
    logic [5:0] wr_addr [$];
    logic [7:0] wr_data [$];
    int acc_len [$];
    int arst_pre, unstable, pen_cyc, done_cnt, done_cyc, rel_cyc, lock_cyc;
    logic [1:0] err_at_done;
    logic arst_at_done;
    bit aborted;

    task automatic cfg_wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        CFG_WE = 1; CFG_ADDR = a; CFG_WDATA = d;
        @(negedge clk);
        CFG_WE = 0;
        if (a < NR) shadow_m[a] = d;
    endtask

    // Number of the first n writes that differ from the image model.
    function automatic int mism(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= wr_addr.size()) m++;
            else if (wr_addr[i] !== 6'(int'(BA) + i) || wr_data[i] !== shadow_m[i]) m++;
        end
        return m;
    endfunction

    // Starts a sequence and plays the APB slave / PLL until DONE settles.
    task automatic run_seq(input int lock_dly, input int abort_at, input bit poke);
        int acc_cyc = 0, nacc = 0;
        bit rel_seen = 0, psel_seen = 0, rdy;
        logic [5:0] a0 = '0;
        logic [7:0] d0 = '0;
        wr_addr.delete(); wr_data.delete(); acc_len.delete();
        arst_pre = 0; unstable = 0; pen_cyc = 0; done_cnt = 0;
        done_cyc = -1; rel_cyc = -1; lock_cyc = -1; aborted = 0;
        @(negedge clk);
        LOCK = 0; START = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            START = 0; CFG_WE = 0;
            if (poke && cyc == 5) begin
                CFG_WE = 1; CFG_ADDR = 6'd0; CFG_WDATA = 8'hFF; START = 1;
            end
            if (DONE) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; err_at_done = ERR; arst_at_done = ARST_N;
                end
            end
            if (PSEL) psel_seen = 1;
            else if (!psel_seen && !ARST_N) arst_pre++;
            if (ARST_N && psel_seen && !rel_seen) begin rel_seen = 1; rel_cyc = cyc; end
            if (lock_dly >= 0 && rel_seen && cyc == rel_cyc + lock_dly) begin
                LOCK = 1; lock_cyc = cyc;
            end
            if (PSEL && PENABLE) begin
                pen_cyc++;
                if (acc_cyc == 0) begin a0 = PADDR; d0 = PWDATA; end
                else if (PADDR !== a0 || PWDATA !== d0) unstable++;
                if (!PWRITE) unstable++;
                acc_cyc++;
                rdy = !stuck && (acc_cyc - 1 >= waits[nacc]);
                PREADY = rdy;
                PSLVERR = rdy && (nacc == slverr_idx);
                if (rdy) begin
                    wr_addr.push_back(a0); wr_data.push_back(d0); acc_len.push_back(acc_cyc);
                    acc_cyc = 0; nacc++;
                end
            end else begin
                PREADY = 0; PSLVERR = 0; acc_cyc = 0;
            end
            if (abort_at >= 0 && nacc == abort_at && PSEL && !PENABLE) begin
                aborted = 1; break;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 3) break;
        end
        PREADY = 0; PSLVERR = 0; START = 0; CFG_WE = 0;
        if (abort_at < 0) begin
            chk_cnt++;
            if (done_cyc < 0) $display("FAIL run_bound: no DONE within 3000 cycles");
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        logic [22:0] obs;
        rst = 1;
        repeat (2) @(negedge clk);
        obs = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, ARST_N, ACTIVE, DONE, ERR, LOCKED};
        chk_cnt++;
        if (obs !== {17'b0, 1'b1, 5'b0}) $display("FAIL reset_outputs: got %h want %h", obs, {17'b0, 1'b1, 5'b0});
        else pass_cnt++;
        rst = 0;
        for (int i = 0; i < NR; i++) shadow_m[i] = '0;
        run_seq(5, -1, 0);
        chk_cnt++;
        if (mism(NR) !== 0) $display("FAIL reset_shadow: %0d bad writes, want 0", mism(NR));
        else pass_cnt++;
    endtask

    task automatic test_basic();
        for (int i = 0; i < NR; i++) cfg_wr(6'(i), 8'(8'h10 + i));
        cfg_wr(6'd8, 8'hAA);
        run_seq(20, -1, 0);
        chk_cnt++;
        if (wr_addr.size() !== NR) $display("FAIL basic_count: got %0d want %0d", wr_addr.size(), NR);
        else pass_cnt++;
        chk_cnt++;
        if (mism(NR) !== 0) $display("FAIL basic_data: %0d bad writes, want 0", mism(NR));
        else pass_cnt++;
        chk_cnt++;
        if (arst_pre !== RC) $display("FAIL basic_prst: got %0d want %0d", arst_pre, RC);
        else pass_cnt++;
        chk_cnt++;
        if (rel_cyc !== RC + 2 * NR) $display("FAIL basic_release: got %0d want %0d", rel_cyc, RC + 2 * NR);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc - lock_cyc !== 3) $display("FAIL basic_lock_lat: got %0d want 3", done_cyc - lock_cyc);
        else pass_cnt++;
        chk_cnt++;
        if ({done_cnt, err_at_done, arst_at_done} !== {32'd1, 2'b00, 1'b1})
            $display("FAIL basic_done: got dones=%0d err=%b arst=%b want 1/00/1", done_cnt, err_at_done, arst_at_done);
        else pass_cnt++;
        chk_cnt++;
        if ({ACTIVE, ERR, PSEL} !== 4'b0000) $display("FAIL basic_idle: got %b want 0000", {ACTIVE, ERR, PSEL});
        else pass_cnt++;
    endtask

    task automatic test_wait();
        waits[4] = 3;
        run_seq(10, -1, 0);
        waits[4] = 0;
        chk_cnt++;
        if (acc_len.size() < 5 || acc_len[4] !== 4)
            $display("FAIL wait_len: got %0d want 4", (acc_len.size() < 5) ? -1 : acc_len[4]);
        else pass_cnt++;
        chk_cnt++;
        if (unstable !== 0) $display("FAIL wait_stable: got %0d unstable cycles want 0", unstable);
        else pass_cnt++;
        chk_cnt++;
        if (mism(NR) !== 0 || err_at_done !== 2'b00) $display("FAIL wait_data: bad=%0d err=%b", mism(NR), err_at_done);
        else pass_cnt++;
        chk_cnt++;
        if (rel_cyc !== RC + 2 * NR + 3) $display("FAIL wait_release: got %0d want %0d", rel_cyc, RC + 2 * NR + 3);
        else pass_cnt++;
    endtask

    task automatic test_slverr();
        slverr_idx = 2;
        run_seq(5, -1, 0);
        slverr_idx = -1;
        chk_cnt++;
        if (pen_cyc !== 3 || wr_addr.size() !== 3) $display("FAIL slverr_count: got %0d accesses want 3", pen_cyc);
        else pass_cnt++;
        chk_cnt++;
        if ({done_cnt, err_at_done, arst_at_done} !== {32'd1, 2'b01, 1'b1})
            $display("FAIL slverr_done: got dones=%0d err=%b arst=%b want 1/01/1", done_cnt, err_at_done, arst_at_done);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        stuck = 1;
        run_seq(5, -1, 0);
        stuck = 0;
        chk_cnt++;
        if (pen_cyc !== AT) $display("FAIL timeout_len: got %0d want %0d", pen_cyc, AT);
        else pass_cnt++;
        chk_cnt++;
        if ({done_cnt, err_at_done, arst_at_done} !== {32'd1, 2'b10, 1'b1})
            $display("FAIL timeout_done: got dones=%0d err=%b arst=%b want 1/10/1", done_cnt, err_at_done, arst_at_done);
        else pass_cnt++;
    endtask

    task automatic test_nolock();
        run_seq(-1, -1, 0);
        chk_cnt++;
        if (done_cyc - rel_cyc !== 1 + LT) $display("FAIL nolock_len: got %0d want %0d", done_cyc - rel_cyc, 1 + LT);
        else pass_cnt++;
        chk_cnt++;
        if (err_at_done !== 2'b11 || ERR !== 2'b11) $display("FAIL nolock_err: got %b/%b want 11", err_at_done, ERR);
        else pass_cnt++;
    endtask

    task automatic test_busy_and_abort();
        int bad = 0;
        logic [22:0] obs;
        CCC_BUSY = 1;
        @(negedge clk); START = 1;
        @(negedge clk); START = 0;
        repeat (25) begin
            @(negedge clk);
            if (PSEL || ACTIVE || !ARST_N) bad++;
        end
        CCC_BUSY = 0;
        chk_cnt++;
        if (bad !== 0) $display("FAIL busy_drop: got %0d active cycles want 0", bad);
        else pass_cnt++;
        run_seq(10, -1, 1);
        chk_cnt++;
        if (done_cnt !== 1 || wr_addr.size() !== NR) $display("FAIL busy_restart: dones=%0d writes=%0d", done_cnt, wr_addr.size());
        else pass_cnt++;
        chk_cnt++;
        if (mism(NR) !== 0) $display("FAIL busy_cfg_ignored: %0d bad writes want 0", mism(NR));
        else pass_cnt++;
        run_seq(10, 3, 0);
        chk_cnt++;
        if (!aborted || mism(3) !== 0) $display("FAIL abort_pre: aborted=%0d bad=%0d", aborted, mism(3));
        else pass_cnt++;
        #1 rst = 1;
        #1;
        obs = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, ARST_N, ACTIVE, DONE, ERR, LOCKED};
        chk_cnt++;
        if (obs !== {17'b0, 1'b1, 5'b0}) $display("FAIL abort_reset: got %h want %h", obs, {17'b0, 1'b1, 5'b0});
        else pass_cnt++;
        @(negedge clk); rst = 0;
        for (int i = 0; i < NR; i++) shadow_m[i] = '0;
        run_seq(8, -1, 0);
        chk_cnt++;
        if (mism(NR) !== 0 || wr_addr.size() !== NR) $display("FAIL abort_shadow_lost: bad=%0d", mism(NR));
        else pass_cnt++;
    endtask

    task automatic test_random();
        int wsum, ld;
        for (int it = 0; it < 4; it++) begin
            repeat (10) cfg_wr(6'($urandom_range(0, 11)), 8'($urandom));
            wsum = 0;
            for (int i = 0; i < NR; i++) begin waits[i] = $urandom_range(0, 2); wsum += waits[i]; end
            ld = $urandom_range(1, 40);
            run_seq(ld, -1, 1);
            chk_cnt++;
            if (mism(NR) !== 0 || wr_addr.size() !== NR) $display("FAIL rand_data[%0d]: bad=%0d n=%0d", it, mism(NR), wr_addr.size());
            else pass_cnt++;
            chk_cnt++;
            if (rel_cyc !== RC + 2 * NR + wsum) $display("FAIL rand_release[%0d]: got %0d want %0d", it, rel_cyc, RC + 2 * NR + wsum);
            else pass_cnt++;
            chk_cnt++;
            if (done_cyc - lock_cyc !== 3 || err_at_done !== 2'b00 || done_cnt !== 1 || unstable !== 0)
                $display("FAIL rand_done[%0d]: lat=%0d err=%b dones=%0d unstable=%0d", it, done_cyc - lock_cyc, err_at_done, done_cnt, unstable);
            else pass_cnt++;
        end
        for (int i = 0; i < 64; i++) waits[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) waits[i] = 0;
        test_reset();
        test_basic();
        test_wait();
        test_slverr();
        test_timeout();
        test_nolock();
        test_busy_and_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
